// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator for the decode stage.
//
// Decodes the immediate selected by imm_op from the raw instruction word and
// carries it through STAGES register slots behind a valid/ready handshake.
//
// Parameters
//   XLEN    datapath width (32 or 64)
//   STAGES  register slots between input and output (1 or 2)
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   flush        drop every in-flight entry and any simultaneous input
//   in_valid     instruction/imm_op valid
//   in_ready     block can take the input this cycle
//   instruction  raw 32-bit instruction word
//   imm_op       format select (NONE, I, S, B, U, J, Z, SH)
//   out_valid    immediate/imm_err valid
//   out_ready    consumer takes the output this cycle
//   immediate    generated immediate, XLEN wide
//   imm_err      illegal-immediate flag travelling with the entry
module imm_gen_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [2:0]      imm_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immediate,
  output logic            imm_err
);

  if (XLEN != 32 && XLEN != 64) begin : gen_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (STAGES != 1 && STAGES != 2) begin : gen_bad_stages
    $error("imm_gen_pipe: STAGES must be 1 or 2");
  end

  localparam logic [2:0] OpNone = 3'b000;
  localparam logic [2:0] OpI    = 3'b001;
  localparam logic [2:0] OpS    = 3'b010;
  localparam logic [2:0] OpB    = 3'b011;
  localparam logic [2:0] OpU    = 3'b100;
  localparam logic [2:0] OpJ    = 3'b101;
  localparam logic [2:0] OpZ    = 3'b110;
  localparam logic [2:0] OpSh   = 3'b111;

  // Opcode bits never feed an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instruction[6:0];

  // Every format fits in 32 bits; Z and SH have bit 31 clear, so a plain sign
  // extension to XLEN also gives their required zero extension.
  logic [31:0]     imm32;
  logic            err_new;
  logic [XLEN-1:0] imm_new;

  always_comb begin
    imm32   = '0;
    err_new = 1'b0;
    unique case (imm_op)
      OpNone: imm32 = '0;
      OpI:    imm32 = {{20{instruction[31]}}, instruction[31:20]};
      OpS:    imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OpB:    imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
      OpU:    imm32 = {instruction[31:12], 12'b0};
      OpJ:    imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};
      OpZ:    imm32 = {27'b0, instruction[19:15]};
      OpSh: begin
        // A 6-bit shamt is illegal on RV32, but the value keeps bit 25.
        imm32   = {26'b0, instruction[25:20]};
        err_new = (XLEN == 32) && instruction[25];
      end
    endcase
  end

  assign imm_new = XLEN'($signed(imm32));

  // Pipeline slots
  logic [STAGES-1:0] valid_q;
  logic [XLEN-1:0]   imm_q [STAGES];
  logic [STAGES-1:0] err_q;

  // slot_ready[k]: the entry in slot k can leave this cycle.
  logic [STAGES-1:0] slot_ready;
  logic [STAGES-1:0] up_valid;
  logic [XLEN-1:0]   up_imm [STAGES];
  logic [STAGES-1:0] up_err;
  logic              in_fire;

  always_comb begin
    slot_ready           = '0;
    slot_ready[STAGES-1] = out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      slot_ready[k] = !valid_q[k+1] || slot_ready[k+1];
    end
  end

  assign in_ready = !valid_q[0] || slot_ready[0];
  assign in_fire  = in_valid && in_ready && !flush;

  // What each slot would load: the input for slot 0, the previous slot otherwise.
  always_comb begin
    up_valid[0] = in_fire;
    up_imm[0]   = imm_new;
    up_err[0]   = err_new;
    for (int k = 1; k < int'(STAGES); k++) begin
      up_valid[k] = valid_q[k-1];
      up_imm[k]   = imm_q[k-1];
      up_err[k]   = err_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        imm_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (!valid_q[k] || slot_ready[k]) begin
          valid_q[k] <= up_valid[k];
          // Data only moves with a real entry so a stalled output stays stable.
          if (up_valid[k]) begin
            imm_q[k] <= up_imm[k];
            err_q[k] <= up_err[k];
          end
        end
      end
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign immediate = imm_q[STAGES-1];
  assign imm_err   = err_q[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe.
// Three instances share the input side: XLEN32/STAGES1 (a), XLEN64/STAGES1 (b)
// and XLEN32/STAGES2 (c). A vector table covers every format; hand-written
// sequences cover stall, flush and mid-stream reset on the two-stage instance.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instruction;
  logic [2:0]  imm_op;

  logic        rdy_a, ov_a, err_a;
  logic [31:0] imm_a;
  logic        rdy_b, ov_b, err_b;
  logic [63:0] imm_b;
  logic        rdy_c, ov_c, err_c;
  logic [31:0] imm_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .instruction(instruction), .imm_op(imm_op), .out_valid(ov_a), .out_ready(out_ready),
    .immediate(imm_a), .imm_err(err_a)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .instruction(instruction), .imm_op(imm_op), .out_valid(ov_b), .out_ready(out_ready),
    .immediate(imm_b), .imm_err(err_b)
  );

  imm_gen_pipe #(.XLEN(32), .STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .instruction(instruction), .imm_op(imm_op), .out_valid(ov_c), .out_ready(out_ready),
    .immediate(imm_c), .imm_err(err_c)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [2:0]  op;
    logic [63:0] exp;   // XLEN=64 value; low half is the XLEN=32 value
    logic        err32;
    logic        err64;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx);
    in_valid    = 1'b1;
    instruction = vecs[idx].instr;
    imm_op      = vecs[idx].op;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, seen;

    vecs[0]  = '{"i_neg",  32'hFFF00093, 3'b001, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vecs[1]  = '{"b_neg",  32'hFE000EE3, 3'b011, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
    vecs[2]  = '{"u_pos",  32'h123450B7, 3'b100, 64'h0000000012345000, 1'b0, 1'b0};
    vecs[3]  = '{"u_neg",  32'h800000B7, 3'b100, 64'hFFFFFFFF80000000, 1'b0, 1'b0};
    vecs[4]  = '{"z_uimm", 32'h000FD073, 3'b110, 64'h000000000000001F, 1'b0, 1'b0};
    vecs[5]  = '{"sh_b25", 32'h02009093, 3'b111, 64'h0000000000000020, 1'b1, 1'b0};
    vecs[6]  = '{"none",   32'hFFFFFFFF, 3'b000, 64'h0000000000000000, 1'b0, 1'b0};
    vecs[7]  = '{"s_pos",  32'h00A12423, 3'b010, 64'h0000000000000008, 1'b0, 1'b0};
    vecs[8]  = '{"j_neg",  32'h800000EF, 3'b101, 64'hFFFFFFFFFFF00000, 1'b0, 1'b0};
    vecs[9]  = '{"j_pos",  32'h008000EF, 3'b101, 64'h0000000000000008, 1'b0, 1'b0};
    vecs[10] = '{"sh_31",  32'h01F09093, 3'b111, 64'h000000000000001F, 1'b0, 1'b0};
    vecs[11] = '{"i_pos",  32'h7FF00093, 3'b001, 64'h00000000000007FF, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instruction = '0; imm_op = '0;
    repeat (3) tick();
    chk("rst_ov_a",  64'(ov_a),  64'(0));
    chk("rst_imm_a", 64'(imm_a), 64'(0));
    chk("rst_err_a", 64'(err_a), 64'(0));
    chk("rst_rdy_a", 64'(rdy_a), 64'(1));
    chk("rst_ov_c",  64'(ov_c),  64'(0));
    chk("rst_rdy_c", 64'(rdy_c), 64'(1));
    rst_n = 1'b1;
    tick();

    // Every format, back to back, one-cycle latency on the single-stage parts
    for (int i = 0; i < 12; i++) begin
      drive(i);
      tick();
      chk($sformatf("%s_ov_a", vecs[i].name),  64'(ov_a),  64'(1));
      chk($sformatf("%s_imm_a", vecs[i].name), 64'(imm_a), 64'(vecs[i].exp[31:0]));
      chk($sformatf("%s_err_a", vecs[i].name), 64'(err_a), 64'(vecs[i].err32));
      chk($sformatf("%s_imm_b", vecs[i].name), imm_b,      vecs[i].exp);
      chk($sformatf("%s_err_b", vecs[i].name), 64'(err_b), 64'(vecs[i].err64));
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("drain_ov_a", 64'(ov_a), 64'(0));
    chk("drain_ov_c", 64'(ov_c), 64'(0));

    // Two-stage stream of 5 with out_ready low in cycles 3..5
    sent = 0;
    got  = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 5) drive(sent);
      else in_valid = 1'b0;
      @(negedge clk);
      if (c == 1) chk("c_lat_c1", 64'(ov_c), 64'(0));
      if (c == 2) chk("c_lat_c2", 64'(ov_c), 64'(1));
      if (c >= 3 && c <= 5) begin
        chk($sformatf("c_stall_rdy%0d", c), 64'(rdy_c), 64'(0));
        chk($sformatf("c_stall_ov%0d", c),  64'(ov_c),  64'(1));
        chk($sformatf("c_stall_imm%0d", c), 64'(imm_c), 64'(vecs[1].exp[31:0]));
      end
      if (ov_c && out_ready) begin
        chk($sformatf("c_order%0d", got), 64'(imm_c), 64'(vecs[got].exp[31:0]));
        got++;
      end
      if (in_valid && rdy_c) sent++;
      tick();
    end
    chk("c_count", 64'(got), 64'(5));
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // Flush with two entries in flight and a simultaneous input
    out_ready = 1'b0;
    drive(0);
    tick();
    drive(1);
    tick();
    chk("fl_pre_ov_c", 64'(ov_c), 64'(1));
    drive(2);
    flush = 1'b1;
    tick();
    chk("fl_ov_c", 64'(ov_c), 64'(0));
    chk("fl_ov_a", 64'(ov_a), 64'(0));
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (ov_c) seen++;
      tick();
    end
    chk("fl_nothing_out", 64'(seen), 64'(0));
    chk("fl_rdy_c", 64'(rdy_c), 64'(1));

    // Reset mid-stream while an erroring entry sits at the output
    out_ready = 1'b0;
    drive(5);
    tick();
    drive(1);
    tick();
    chk("mr_pre_imm_c", 64'(imm_c), 64'h20);
    chk("mr_pre_err_c", 64'(err_c), 64'(1));
    chk("mr_pre_err_a", 64'(err_a), 64'(1));
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(3);
    tick();
    chk("mr_ov_c",  64'(ov_c),  64'(0));
    chk("mr_imm_c", 64'(imm_c), 64'(0));
    chk("mr_err_c", 64'(err_c), 64'(0));
    chk("mr_ov_a",  64'(ov_a),  64'(0));
    chk("mr_err_a", 64'(err_a), 64'(0));
    chk("mr_imm_b", imm_b,      64'(0));
    rst_n = 1'b1;
    drive(4);
    tick();
    in_valid = 1'b0;
    chk("mr_post_c1", 64'(ov_c), 64'(0));
    tick();
    chk("mr_post_c2",  64'(ov_c),  64'(1));
    chk("mr_post_imm", 64'(imm_c), 64'h1F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
